// File: rtl/game_flow_fsm.sv
// Match-level pong controller: menu/start, serve gating, scoring, winner
// detection and a frame-counted cool-down between a point and the next serve.
module game_flow_fsm #(
  parameter int unsigned WIN_SCORE          = 7,
  parameter int unsigned SERVE_DELAY_FRAMES = 60,
  parameter int unsigned SCORE_W            = 4
) (
  input  logic               clk65MHz,
  input  logic               rst,
  input  logic               end_of_frame,
  input  logic               btn_single,
  input  logic               btn_multi,
  input  logic               btn_serve,
  input  logic               point_player_1,
  input  logic               point_player_2,
  output logic               screen_idle,
  output logic               screen_multi,
  output logic               serve,
  output logic [SCORE_W-1:0] score_player_1,
  output logic [SCORE_W-1:0] score_player_2,
  output logic [1:0]         winner
);

  localparam int unsigned CNT_W =
    (SERVE_DELAY_FRAMES < 2) ? 1 : $clog2(SERVE_DELAY_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SERVE,
    S_PLAY,
    S_COOLDOWN,
    S_GAME_OVER
  } state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               screen_idle_n, screen_multi_n, serve_n;
  logic [SCORE_W-1:0] score_player_1_n, score_player_2_n;
  logic [1:0]         winner_n;

  // Button history resets high so a button held through reset gives no edge.
  logic prev_single, prev_multi, prev_serve;
  logic edge_single, edge_multi, edge_serve;
  logic [SCORE_W-1:0] inc_1, inc_2;

  assign edge_single = btn_single & ~prev_single;
  assign edge_multi  = btn_multi  & ~prev_multi;
  assign edge_serve  = btn_serve  & ~prev_serve;
  assign inc_1       = score_player_1 + SCORE_W'(1);
  assign inc_2       = score_player_2 + SCORE_W'(1);

  always_ff @(posedge clk65MHz) begin
    if (rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      screen_idle    <= 1'b1;
      screen_multi   <= 1'b0;
      serve          <= 1'b0;
      score_player_1 <= '0;
      score_player_2 <= '0;
      winner         <= 2'b00;
      prev_single    <= 1'b1;
      prev_multi     <= 1'b1;
      prev_serve     <= 1'b1;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      screen_idle    <= screen_idle_n;
      screen_multi   <= screen_multi_n;
      serve          <= serve_n;
      score_player_1 <= score_player_1_n;
      score_player_2 <= score_player_2_n;
      winner         <= winner_n;
      prev_single    <= btn_single;
      prev_multi     <= btn_multi;
      prev_serve     <= btn_serve;
    end
  end

  always_comb begin
    state_n          = state;
    cnt_n            = cnt;
    screen_idle_n    = screen_idle;
    screen_multi_n   = screen_multi;
    serve_n          = 1'b0;
    score_player_1_n = score_player_1;
    score_player_2_n = score_player_2;
    winner_n         = winner;

    case (state)
      S_IDLE: begin
        if (edge_multi || edge_single) begin
          state_n          = S_WAIT_SERVE;
          screen_multi_n   = edge_multi;
          screen_idle_n    = 1'b0;
          score_player_1_n = '0;
          score_player_2_n = '0;
          winner_n         = 2'b00;
        end
      end
      S_WAIT_SERVE: begin
        if (edge_serve) begin
          state_n = S_PLAY;
          serve_n = 1'b1;
        end
      end
      S_PLAY: begin
        // Simultaneous points credit player 1 only.
        if (point_player_1) begin
          score_player_1_n = inc_1;
          if (inc_1 == SCORE_W'(WIN_SCORE)) begin
            state_n  = S_GAME_OVER;
            winner_n = 2'b01;
          end else begin
            state_n = S_COOLDOWN;
            cnt_n   = CNT_W'(SERVE_DELAY_FRAMES);
          end
        end else if (point_player_2) begin
          score_player_2_n = inc_2;
          if (inc_2 == SCORE_W'(WIN_SCORE)) begin
            state_n  = S_GAME_OVER;
            winner_n = 2'b10;
          end else begin
            state_n = S_COOLDOWN;
            cnt_n   = CNT_W'(SERVE_DELAY_FRAMES);
          end
        end
      end
      S_COOLDOWN: begin
        if (cnt == '0) begin
          state_n = S_WAIT_SERVE;
        end else if (end_of_frame) begin
          cnt_n = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state_n = S_WAIT_SERVE;
        end
      end
      S_GAME_OVER: begin
        if (edge_serve) begin
          state_n       = S_IDLE;
          screen_idle_n = 1'b1;
        end
      end
      default: begin
        state_n       = S_IDLE;
        screen_idle_n = 1'b1;
      end
    endcase
  end

endmodule
